bus_interconnect_n: RTL
=======================

Name: bus_interconnect_n

Overview:
- Parametrised single-master, N-slave interconnect for the CPU memory-arbiter handshake bus.
- Latches each master request, decodes it against per-slave base/mask regions, and forwards it to exactly one slave.
- Waits for that slave's completion and returns read data plus an error flag.
- Adds behaviour the fixed decoder lacks: request registering, unmapped-address error, per-access timeout and a sticky fault-address register.

Parameters:
N_SLAVES, 4, number of slave channels (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
BASE_ADDRS, {32'h0006_0000,32'h0004_0000,32'h0002_0000,32'h0000_0000}, packed N_SLAVES*ADDR_W region bases, slave 0 in LSBs
ADDR_MASKS, {4{32'hFFFE_0000}}, packed N_SLAVES*ADDR_W; slave i hits when (addr & mask_i) == base_i
TIMEOUT_CYCLES, 255, max ACCESS cycles before error; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m_rd_i  in  1  master read request, level, held until m_ready_o
m_wr_i  in  1  master write request, level, held until m_ready_o
m_addr_i  in  ADDR_W  master byte address
m_wdata_i  in  DATA_W  master write data
m_bsel_i  in  DATA_W/8  byte enables
m_ready_o  out  1  one-cycle completion pulse
m_rdata_o  out  DATA_W  read data, valid while m_ready_o=1
m_err_o  out  1  error flag, valid while m_ready_o=1
s_rd_o  out  N_SLAVES  per-slave read strobe, level
s_wr_o  out  N_SLAVES  per-slave write strobe, level
s_addr_o  out  ADDR_W  latched address, shared by all slaves
s_wdata_o  out  DATA_W  latched write data, shared
s_bsel_o  out  DATA_W/8  latched byte enables, shared
s_ready_i  in  N_SLAVES  per-slave completion pulse
s_rdata_i  in  N_SLAVES*DATA_W  per-slave read data, slave 0 in LSBs
fault_addr_o  out  ADDR_W  address of the most recent errored access (sticky)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset asserted mid-access: strobes drop asynchronously and FSM returns to IDLE. No response is issued.
- States and transitions:
  - IDLE: if m_rd_i|m_wr_i, latch addr/wdata/bsel/op and the decoded slave index and miss flag, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS, mapped: drive s_rd_o[idx] or s_wr_o[idx] from latched op; other bits stay 0.
    - s_ready_i[idx]=1: capture s_rdata_i slice (reads; 0 for writes) and go to RESP with err=0.
    - counter == TIMEOUT_CYCLES-1 with no ready: drop strobe and go to RESP with err=1, rdata=0.
  - ACCESS, unmapped or illegal (miss, or m_rd_i&m_wr_i both set at latch): no strobe; go to RESP next cycle with err=1.
  - RESP: m_ready_o=1 and m_err_o=err for exactly one cycle; fault_addr_o updated when err=1; go to IDLE.
- Decode: priority by lowest index when regions overlap. Decode is performed on m_addr_i in IDLE only.
- Latency:
  - Request seen at cycle t → strobe at t+1.
  - Slave ready at t+1+k → m_ready_o at t+2+k.
  - Unmapped request → m_ready_o at t+2.
- s_ready_i is ignored outside ACCESS and on non-selected bits, so late ready after a timeout is discarded.
- Counter: cleared on entering ACCESS, increments each ACCESS cycle, width clog2(TIMEOUT_CYCLES+1). Saturates; never wraps.
- Master must deassert or change its request in the cycle after m_ready_o. A request still high in IDLE is treated as a new access.
- m_rdata_o holds its value outside RESP; only meaningful with m_ready_o.

Decomposition:
- Shared package bus_pkg holds:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - default region constants for RAM, LED and AXI;
  - ERR_RDATA = 0.
- One sub-module: bus_addr_decoder, combinational. Inputs: addr, BASE_ADDRS, ADDR_MASKS. Outputs: one-hot hit vector, priority index, miss flag.

Test Plan:
- Read slave 0: m_rd_i=1, addr 0x0000_0010; slave 0 ready one cycle after its strobe with 0xCAFE_0001 → s_rd_o=4'b0001 at t+1, m_ready_o at t+3, m_rdata_o=0xCAFE_0001, m_err_o=0.
- Write slave 2: m_wr_i=1, addr 0x0004_0004, data 0x1234_5678, bsel 4'b0011 → s_wr_o=4'b0100 with s_wdata_o=0x1234_5678 and s_bsel_o=4'b0011 held until slave ready; m_err_o=0.
- Unmapped: addr 0x0010_0000 read → no strobe ever; m_ready_o at t+2; m_err_o=1; fault_addr_o=0x0010_0000.
- Timeout: TIMEOUT_CYCLES=8, slave 3 never readies → strobe high exactly 8 cycles then drops; m_err_o=1. A ready pulse two cycles later is ignored and m_ready_o stays 0.
- Back-to-back: second read issued the cycle after m_ready_o → second access starts cleanly and returns correct data.
- Reset mid-ACCESS: rst_i asserted while s_rd_o[1]=1 → s_rd_o=0 immediately, no m_ready_o; after release the FSM is in IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared state encoding, default region map and sizing helpers for the
// single-master / N-slave bus interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Default memory map: 128 KiB windows
  localparam logic [31:0] REGION_MASK = 32'hFFFE_0000;
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] LED_BASE    = 32'h0002_0000;
  localparam logic [31:0] AXI_BASE    = 32'h0004_0000;

  // Read data returned with any errored response
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero-cycle timeout still needs a one-bit counter to keep widths legal
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask region decoder; the lowest-numbered region wins
// whenever several regions claim the same address.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                         N_SLAVES   = 4,
  parameter int                         ADDR_W     = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS = '0,
  localparam int                        IDX_W      = idx_width(N_SLAVES)
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_SLAVES-1:0] hit,
  output logic [IDX_W-1:0]    idx,
  output logic                miss
);

  logic [N_SLAVES-1:0] raw_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_region
      assign raw_hit[gi] =
        (addr & ADDR_MASKS[gi*ADDR_W +: ADDR_W]) == BASE_ADDRS[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Isolate the lowest set bit so the hit vector stays one-hot on overlap
  assign hit  = raw_hit & (~raw_hit + N_SLAVES'(1));
  assign miss = ~|raw_hit;

  always_comb begin
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (raw_hit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bus_interconnect_n.sv
// Single-master, N-slave interconnect: registers each request, routes it to
// one decoded slave, and returns data/error with timeout and fault capture.
module bus_interconnect_n
  import bus_pkg::*;
#(
  parameter int                         N_SLAVES       = 4,
  parameter int                         ADDR_W         = 32,
  parameter int                         DATA_W         = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS     = {32'h0006_0000, AXI_BASE, LED_BASE, RAM_BASE},
  parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS     = {4{REGION_MASK}},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_rd_i,
  input  logic                         m_wr_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [DATA_W/8-1:0]          m_bsel_i,
  output logic                         m_ready_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_err_o,
  output logic [N_SLAVES-1:0]          s_rd_o,
  output logic [N_SLAVES-1:0]          s_wr_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_bsel_o,
  input  logic [N_SLAVES-1:0]          s_ready_i,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  output logic [ADDR_W-1:0]            fault_addr_o
);

  localparam int BSEL_W  = DATA_W / 8;
  localparam int IDX_W   = idx_width(N_SLAVES);
  localparam int CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

  bus_state_e state_reg, state_next;

  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BSEL_W-1:0]   bsel_reg;
  logic                wr_reg;
  logic                miss_reg;
  logic [N_SLAVES-1:0] sel_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                err_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [ADDR_W-1:0]   fault_reg;

  logic                latch_req;
  logic                to_resp;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_rdata;
  logic                ready_sel;
  logic                timeout_hit;
  logic                strobe_en;
  logic [DATA_W-1:0]   slave_rdata;

  logic [N_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_miss;

  bus_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decoder (
    .addr (m_addr_i),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  // Only the latched slave's ready counts; everything else is ignored
  assign ready_sel   = |(s_ready_i & sel_reg);
  assign slave_rdata = s_rdata_i[idx_reg*DATA_W +: DATA_W];
  assign timeout_hit = TO_EN && (cnt_reg == CNT_W'(TO_LAST));

  always_comb begin
    state_next = state_reg;
    latch_req  = 1'b0;
    to_resp    = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (m_rd_i | m_wr_i) begin
          latch_req  = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (miss_reg) begin
          to_resp    = 1'b1;
          resp_err   = 1'b1;
          resp_rdata = DATA_W'(ERR_RDATA);
        end else if (ready_sel) begin
          to_resp    = 1'b1;
          resp_rdata = wr_reg ? '0 : slave_rdata;
        end else if (timeout_hit) begin
          to_resp    = 1'b1;
          resp_err   = 1'b1;
          resp_rdata = DATA_W'(ERR_RDATA);
        end
        if (to_resp) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Request capture; a simultaneous read+write is treated like an unmapped hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      bsel_reg  <= '0;
      wr_reg    <= 1'b0;
      miss_reg  <= 1'b0;
      sel_reg   <= '0;
      idx_reg   <= '0;
    end else if (latch_req) begin
      addr_reg  <= m_addr_i;
      wdata_reg <= m_wdata_i;
      bsel_reg  <= m_bsel_i;
      wr_reg    <= m_wr_i;
      miss_reg  <= dec_miss | (m_rd_i & m_wr_i);
      sel_reg   <= dec_hit;
      idx_reg   <= dec_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (latch_req) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS && cnt_reg != '1) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Response data and the sticky fault address are captured on entry to RESP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg   <= 1'b0;
      rdata_reg <= '0;
      fault_reg <= '0;
    end else if (to_resp) begin
      err_reg   <= resp_err;
      rdata_reg <= resp_rdata;
      if (resp_err) fault_reg <= addr_reg;
    end
  end

  assign strobe_en = (state_reg == ST_ACCESS) && !miss_reg;
  assign s_rd_o    = (strobe_en && !wr_reg) ? sel_reg : '0;
  assign s_wr_o    = (strobe_en &&  wr_reg) ? sel_reg : '0;
  assign s_addr_o  = addr_reg;
  assign s_wdata_o = wdata_reg;
  assign s_bsel_o  = bsel_reg;

  assign m_ready_o    = (state_reg == ST_RESP);
  assign m_err_o      = (state_reg == ST_RESP) & err_reg;
  assign m_rdata_o    = rdata_reg;
  assign fault_addr_o = fault_reg;

endmodule
